// File: rtl/bsg_dff_pipe_reset.sv
// els_p-deep valid/ready register pipeline with bubble collapsing, flush and occupancy count.
// Every data register loads reset_val_p on a synchronous active-low reset.

module bsg_dff_pipe_reset_stage #(
  parameter int                 width_p     = 64,
  parameter logic [width_p-1:0] reset_val_p = '0
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               flush_i,
  input  logic               adv,
  input  logic               in_v,
  input  logic [width_p-1:0] in_data,
  output logic               v,
  output logic [width_p-1:0] data
);

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      v    <= 1'b0;
      data <= reset_val_p;
    end else if (flush_i) begin
      v <= 1'b0;
    end else if (adv) begin
      v <= in_v;
      // Data is only loaded from a valid upstream word, so bubbles never overwrite it.
      if (in_v) data <= in_data;
    end
  end

endmodule

module bsg_dff_pipe_reset #(
  parameter int                 width_p     = 64,
  parameter int                 els_p       = 2,
  parameter logic [width_p-1:0] reset_val_p = '0,
  localparam int                cnt_w_lp    = $clog2(els_p + 1)
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                flush_i,
  input  logic                v_i,
  input  logic [width_p-1:0]  data_i,
  output logic                ready_o,
  output logic                v_o,
  output logic [width_p-1:0]  data_o,
  input  logic                ready_i,
  output logic [cnt_w_lp-1:0] count_o
);

  logic [els_p-1:0]              v_r;
  logic [els_p-1:0][width_p-1:0] data_r;
  logic [els_p:0]                adv;
  logic [cnt_w_lp-1:0]           cnt;

  // An invalid stage always advances, letting holes close under output backpressure.
  always_comb begin
    adv        = '0;
    adv[els_p] = ready_i;
    for (int k = els_p - 1; k >= 0; k--) adv[k] = ~v_r[k] | adv[k+1];
  end

  assign ready_o = adv[0] & reset_n_i & ~flush_i;

  for (genvar k = 0; k < els_p; k++) begin : g_stage
    logic               in_v;
    logic [width_p-1:0] in_data;

    if (k == 0) begin : g_head
      assign in_v    = v_i & ready_o;
      assign in_data = data_i;
    end else begin : g_body
      assign in_v    = v_r[k-1];
      assign in_data = data_r[k-1];
    end

    bsg_dff_pipe_reset_stage #(
      .width_p    (width_p),
      .reset_val_p(reset_val_p)
    ) stage (
      .clk_i    (clk_i),
      .reset_n_i(reset_n_i),
      .flush_i  (flush_i),
      .adv      (adv[k]),
      .in_v     (in_v),
      .in_data  (in_data),
      .v        (v_r[k]),
      .data     (data_r[k])
    );
  end

  always_comb begin
    cnt = '0;
    for (int k = 0; k < els_p; k++) cnt = cnt + cnt_w_lp'(v_r[k]);
  end

  assign count_o = cnt;
  assign v_o     = v_r[els_p-1];
  assign data_o  = data_r[els_p-1];

endmodule
